// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared AES/GCM widths, GCTR controller state type and inc32.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int RND_SIZE = 128;
    localparam int WRD_SIZE = 32;
    localparam int CTR_SIZE = WRD_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ_J0    = 3'd1,
        ST_WAIT_J0   = 3'd2,
        ST_WAIT_DATA = 3'd3,
        ST_REQ_CTR   = 3'd4,
        ST_WAIT_CTR  = 3'd5,
        ST_OUT       = 3'd6
    } gctr_state_e;

    // Only the low counter word rolls over; the IV part is never touched.
    function automatic logic [RND_SIZE-1:0] inc32(input logic [RND_SIZE-1:0] blk);
        return {blk[RND_SIZE-1:CTR_SIZE],
                blk[CTR_SIZE-1:0] + {{(CTR_SIZE-1){1'b0}}, 1'b1}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_gctr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_gctr_ctrl_if
// Brief    : Message, AES-core and output handshakes of the GCTR controller.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_gctr_ctrl_if #(
    parameter int RND_SIZE = aes_pkg::RND_SIZE
);
    logic                i_start;
    logic [RND_SIZE-1:0] i_j0;
    logic                i_data_valid;
    logic [RND_SIZE-1:0] i_data;
    logic                i_data_last;
    logic                o_data_ready;
    logic                o_aes_en;
    logic [RND_SIZE-1:0] o_aes_msg;
    logic                i_aes_ready;
    logic                i_aes_valid;
    logic [RND_SIZE-1:0] i_aes_cypher;
    logic                o_valid;
    logic [RND_SIZE-1:0] o_data;
    logic                o_last;
    logic                i_ready;
    logic [RND_SIZE-1:0] o_ek_j0;
    logic                o_ek_j0_valid;
    logic                o_busy;

    // Controller side
    modport slave (
        input  i_start, i_j0, i_data_valid, i_data, i_data_last,
               i_aes_ready, i_aes_valid, i_aes_cypher, i_ready,
        output o_data_ready, o_aes_en, o_aes_msg, o_valid, o_data, o_last,
               o_ek_j0, o_ek_j0_valid, o_busy
    );

    // Surrounding logic side (message source, AES core, sink)
    modport master (
        output i_start, i_j0, i_data_valid, i_data, i_data_last,
               i_aes_ready, i_aes_valid, i_aes_cypher, i_ready,
        input  o_data_ready, o_aes_en, o_aes_msg, o_valid, o_data, o_last,
               o_ek_j0, o_ek_j0_valid, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/aes_gctr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_gctr_ctrl
// Brief    : GCTR sequencer: E(K,J0), then one AES counter block per data block.
// Revision : 1.0 - initial release
// ============================================================================
module aes_gctr_ctrl #(
    parameter int RND_SIZE = aes_pkg::RND_SIZE,
    parameter int CTR_SIZE = aes_pkg::CTR_SIZE
) (
    input logic            clk,
    input logic            rst,
    aes_gctr_ctrl_if.slave bus
);
    import aes_pkg::*;

    gctr_state_e         state_q, state_d;
    logic [RND_SIZE-1:0] ctr_blk_q, ctr_blk_d;
    logic [RND_SIZE-1:0] data_q, data_d;
    logic                last_q, last_d;
    logic [RND_SIZE-1:0] out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic                out_valid_q, out_valid_d;
    logic [RND_SIZE-1:0] ek_j0_q, ek_j0_d;
    logic                ek_valid_q, ek_valid_d;
    logic [RND_SIZE-1:0] w_ctr_inc;
    logic                w_data_ready;

    generate
        if (RND_SIZE == aes_pkg::RND_SIZE && CTR_SIZE == aes_pkg::CTR_SIZE) begin : g_pkg_inc
            assign w_ctr_inc = inc32(ctr_blk_q);
        end else begin : g_param_inc
            assign w_ctr_inc = {ctr_blk_q[RND_SIZE-1:CTR_SIZE],
                                ctr_blk_q[CTR_SIZE-1:0] + {{(CTR_SIZE-1){1'b0}}, 1'b1}};
        end
    endgenerate

    // Ready is held off during the E(K,J0) pulse so the tag key leads the first block.
    assign w_data_ready = (state_q == ST_WAIT_DATA) && !ek_valid_q;

    always_comb begin
        state_d     = state_q;
        ctr_blk_d   = ctr_blk_q;
        data_d      = data_q;
        last_d      = last_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        ek_j0_d     = ek_j0_q;
        ek_valid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    ctr_blk_d = bus.i_j0;
                    state_d   = ST_REQ_J0;
                end
            end
            ST_REQ_J0: begin
                if (bus.i_aes_ready) state_d = ST_WAIT_J0;
            end
            ST_WAIT_J0: begin
                if (bus.i_aes_valid) begin
                    ek_j0_d    = bus.i_aes_cypher;
                    ek_valid_d = 1'b1;
                    ctr_blk_d  = w_ctr_inc;
                    state_d    = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (w_data_ready && bus.i_data_valid) begin
                    data_d  = bus.i_data;
                    last_d  = bus.i_data_last;
                    state_d = ST_REQ_CTR;
                end
            end
            ST_REQ_CTR: begin
                if (bus.i_aes_ready) state_d = ST_WAIT_CTR;
            end
            ST_WAIT_CTR: begin
                if (bus.i_aes_valid) begin
                    out_data_d  = data_q ^ bus.i_aes_cypher;
                    out_last_d  = last_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (bus.i_ready) begin
                    ctr_blk_d   = w_ctr_inc;
                    out_valid_d = 1'b0;
                    state_d     = out_last_q ? ST_IDLE : ST_WAIT_DATA;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ctr_blk_q   <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ek_j0_q     <= '0;
            ek_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_blk_q   <= ctr_blk_d;
            data_q      <= data_d;
            last_q      <= last_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            ek_j0_q     <= ek_j0_d;
            ek_valid_q  <= ek_valid_d;
        end
    end

    // The request leaves the REQ_* state on the same edge, so this is a single-cycle pulse.
    assign bus.o_aes_en      = ((state_q == ST_REQ_J0) || (state_q == ST_REQ_CTR)) && bus.i_aes_ready;
    assign bus.o_aes_msg     = ctr_blk_q;
    assign bus.o_data_ready  = w_data_ready;
    assign bus.o_valid       = out_valid_q;
    assign bus.o_data        = out_data_q;
    assign bus.o_last        = out_last_q;
    assign bus.o_ek_j0       = ek_j0_q;
    assign bus.o_ek_j0_valid = ek_valid_q;
    assign bus.o_busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_gctr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_gctr_ctrl
// Brief    : Randomised scoreboard bench for aes_gctr_ctrl with an AES core stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_gctr_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_gctr_ctrl_if bus ();

    aes_gctr_ctrl #(.RND_SIZE(128), .CTR_SIZE(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [127:0] ek_q[$];
    logic [128:0] exp_q[$];
    logic [127:0] blk_data[8];

    int aes_mode = 0;
    int lat_min  = 0;
    int lat_max  = 3;
    bit stub_flush = 1'b0;
    bit stray      = 1'b0;

    task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] fake_aes(input logic [127:0] m);
        logic [31:0] mix;
        mix = (m[31:0] * 32'h9e3779b1) ^ m[127:96];
        return {m[95:0], m[127:96]} ^ {4{mix}} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    // mode 1: AES-128 with an all-zero key for the two counter blocks used; mode 2: echo
    function automatic logic [127:0] aes_resp(input logic [127:0] m);
        if (aes_mode == 1) begin
            if (m == 128'h1) return 128'h58e2fccefa7e3061367f1d57a4e7455a;
            if (m == 128'h2) return 128'h0388dace60b6a392f328c2b971b2fe78;
            return 128'h0;
        end
        if (aes_mode == 2) return m;
        return fake_aes(m);
    endfunction

    // AES core stub: one request at a time, random latency and ready gaps
    logic [127:0] req_msg;
    bit req_seen = 1'b0;
    bit pend     = 1'b0;
    int lat      = 0;
    int aes_hold = 0;

    always @(negedge clk) begin
        if (!rst && bus.o_aes_en === 1'b1) begin
            req_seen = 1'b1;
            req_msg  = bus.o_aes_msg;
        end
    end

    always @(posedge clk) begin
        #1;
        bus.i_aes_valid = 1'b0;
        if (stub_flush) begin
            pend = 1'b0; req_seen = 1'b0; stub_flush = 1'b0;
        end else if (req_seen) begin
            req_seen = 1'b0; pend = 1'b1; lat = $urandom_range(lat_min, lat_max);
        end else if (pend) begin
            if (lat == 0) begin
                bus.i_aes_valid  = 1'b1;
                bus.i_aes_cypher = aes_resp(req_msg);
                pend = 1'b0;
            end else lat--;
        end
        if (stray) begin
            bus.i_aes_valid  = 1'b1;
            bus.i_aes_cypher = {$urandom, $urandom, $urandom, $urandom};
            stray = 1'b0;
        end
        if (aes_hold > 0) aes_hold--;
        else if ($urandom_range(0, 4) == 0) aes_hold = $urandom_range(1, 4);
        bus.i_aes_ready = !pend && !req_seen && (aes_hold == 0);
    end

    // Downstream sink with occasional 5-cycle stalls
    int rdy_hold = 0;
    always @(posedge clk) begin
        #1;
        if (rdy_hold > 0) begin
            bus.i_ready = 1'b0; rdy_hold--;
        end else if ($urandom_range(0, 5) == 0) begin
            bus.i_ready = 1'b0; rdy_hold = 4;
        end else bus.i_ready = 1'b1;
    end

    // Monitor / scoreboard
    bit           held = 1'b0;
    logic [128:0] held_out;
    bit           ek_got = 1'b0;
    bit           prev_ready = 1'b0;
    bit           outst = 1'b0;
    logic [127:0] outst_msg;

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0; outst = 1'b0; ek_got = 1'b0; prev_ready = 1'b0;
        end else begin
            if (!bus.o_busy) ek_got = 1'b0;
            if (bus.o_data_ready && !prev_ready) check("ek_before_ready", {128'h0, ek_got}, 129'h1);
            prev_ready = bus.o_data_ready;
            if (bus.o_ek_j0_valid) begin
                if (ek_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ek_unexpected: actual pulse %h required none", bus.o_ek_j0);
                end else check("ek_j0", {1'b0, bus.o_ek_j0}, {1'b0, ek_q.pop_front()});
                ek_got = 1'b1;
            end
            if (outst) begin
                check("aes_msg_stable", {1'b0, bus.o_aes_msg}, {1'b0, outst_msg});
                if (bus.i_aes_valid) outst = 1'b0;
            end
            if (bus.o_aes_en) begin
                check("aes_en_single", {127'h0, outst, !bus.i_aes_ready}, 129'h0);
                outst = 1'b1;
                outst_msg = bus.o_aes_msg;
            end
            if (bus.o_valid) begin
                if (held) check("out_stable", {bus.o_last, bus.o_data}, held_out);
                check("out_quiet", {127'h0, bus.o_data_ready, bus.o_aes_en}, 129'h0);
                if (bus.i_ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL out_unexpected: actual %h required none", bus.o_data);
                    end else check("out_data", {bus.o_last, bus.o_data}, exp_q.pop_front());
                end else begin
                    held = 1'b1;
                    held_out = {bus.o_last, bus.o_data};
                end
            end else if (held) begin
                checks++; errors++; held = 1'b0;
                $display("FAIL out_dropped: actual o_valid 0 required 1");
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        do begin @(negedge clk); t++; end while (bus.o_busy && t < 1000);
        if (bus.o_busy) begin
            checks++; errors++;
            $display("FAIL idle_timeout: actual o_busy 1 required 0");
        end
        @(posedge clk); #1;
    endtask

    task automatic inject_start();
        int t = 0;
        logic [127:0] m;
        do begin @(negedge clk); t++; end while (!bus.o_data_ready && t < 500);
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        bus.i_j0    = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk); m = bus.o_aes_msg;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        @(negedge clk);
        check("start_ignored_busy", {128'h0, bus.o_busy}, 129'h1);
        check("start_ignored_ctr", {1'b0, bus.o_aes_msg}, {1'b0, m});
        @(posedge clk); #1;
    endtask

    task automatic send_block(input logic [127:0] d, input bit last, input bit inject);
        int t = 0;
        bit acc = 1'b0;
        if (inject) inject_start();
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        bus.i_data = d; bus.i_data_last = last; bus.i_data_valid = 1'b1;
        while (!acc && t < 500) begin
            @(negedge clk); acc = bus.o_data_ready;
            @(posedge clk); #1; t++;
        end
        bus.i_data_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL data_accept_timeout: actual o_data_ready 0 required 1");
        end
    endtask

    task automatic start_msg(input logic [127:0] j0);
        bus.i_j0 = j0; bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
    endtask

    task automatic run_msg(input logic [127:0] j0, input int n, input bit use_model);
        wait_idle();
        if (use_model) begin
            ek_q.push_back(fake_aes(j0));
            for (int b = 0; b < n; b++)
                exp_q.push_back({b == n - 1,
                                 blk_data[b] ^ fake_aes({j0[127:32], j0[31:0] + 32'(b + 1)})});
        end
        start_msg(j0);
        for (int b = 0; b < n; b++)
            send_block(blk_data[b], b == n - 1, use_model && ($urandom_range(0, 3) == 0));
        wait_idle();
        @(negedge clk);
        check("drain", {65'h0, 32'(exp_q.size()), 32'(ek_q.size())}, 129'h0);
    endtask

    initial begin
        logic [127:0] j0;
        int n;
        bus.i_start = 1'b0; bus.i_j0 = '0; bus.i_data_valid = 1'b0; bus.i_data = '0;
        bus.i_data_last = 1'b0; bus.i_aes_ready = 1'b0; bus.i_aes_valid = 1'b0;
        bus.i_aes_cypher = '0; bus.i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ctl", {121'h0, bus.o_valid, bus.o_last, bus.o_busy, bus.o_data_ready,
                            bus.o_aes_en, bus.o_ek_j0_valid, 2'b00}, 129'h0);
        check("reset_data", {1'b0, bus.o_data | bus.o_ek_j0 | bus.o_aes_msg}, 129'h0);

        // GCM test case 2: zero key, J0 = 1, one zero block
        aes_mode = 1;
        blk_data[0] = '0;
        ek_q.push_back(128'h58e2fccefa7e3061367f1d57a4e7455a);
        exp_q.push_back({1'b1, 128'h0388dace60b6a392f328c2b971b2fe78});
        run_msg(128'h1, 1, 1'b0);

        // Echo core across the 32-bit counter wrap
        aes_mode = 2;
        j0 = {$urandom, $urandom, $urandom, 32'hFFFFFFFE};
        for (int b = 0; b < 3; b++) blk_data[b] = '0;
        ek_q.push_back(j0);
        exp_q.push_back({1'b0, j0[127:32], 32'hFFFFFFFF});
        exp_q.push_back({1'b0, j0[127:32], 32'h00000000});
        exp_q.push_back({1'b1, j0[127:32], 32'h00000001});
        run_msg(j0, 3, 1'b0);

        aes_mode = 0;
        for (int m = 0; m < 30; m++) begin
            n = $urandom_range(1, 5);
            j0 = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 2) == 0) j0[31:0] = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
            for (int b = 0; b < n; b++) blk_data[b] = {$urandom, $urandom, $urandom, $urandom};
            run_msg(j0, n, 1'b1);
        end

        // Reset while a counter request is outstanding, then a stray core response
        lat_min = 8; lat_max = 8;
        wait_idle();
        j0 = {$urandom, $urandom, $urandom, $urandom};
        ek_q.push_back(fake_aes(j0));
        start_msg(j0);
        send_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.o_aes_en && n < 100);
        repeat (2) @(negedge clk);
        check("in_wait_ctr", {126'h0, bus.o_busy, bus.o_valid, bus.o_data_ready}, 129'h4);
        stub_flush = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete(); ek_q.delete();
        lat_min = 0; lat_max = 3;
        @(negedge clk); stray = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_ctl", {123'h0, bus.o_valid, bus.o_last, bus.o_busy, bus.o_data_ready,
                                   bus.o_aes_en, bus.o_ek_j0_valid}, 129'h0);
            check("post_rst_data", {1'b0, bus.o_data | bus.o_ek_j0 | bus.o_aes_msg}, 129'h0);
        end

        for (int m = 0; m < 2; m++) begin
            j0 = {$urandom, $urandom, $urandom, $urandom};
            for (int b = 0; b < 2; b++) blk_data[b] = {$urandom, $urandom, $urandom, $urandom};
            run_msg(j0, 2, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: actual simulation still running required finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_gctr_ctrl.md
AES_GCTR_CTRL -- requirements
Module: aes_gctr_ctrl

Interface
REQ-001 Parameter RND_SIZE, default 128, AES block width in bits.
REQ-002 Parameter CTR_SIZE, default 32, width of the inc32 counter field (low bits of the counter block).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 i_start  in  1  one-cycle pulse; begins a message; honoured in IDLE only.
REQ-006 i_j0  in  RND_SIZE  pre-counter block J0, sampled with i_start.
REQ-007 i_data_valid / i_data[RND_SIZE] / i_data_last  in  1/128/1  input block handshake; i_data_last marks the final block.
REQ-008 o_data_ready  out  1  input block accepted when i_data_valid and o_data_ready are both high.
REQ-009 o_aes_en / o_aes_msg  out  1/128  request to AES core (i_en / i_msg side); o_aes_en is a one-cycle pulse.
REQ-010 i_aes_ready / i_aes_valid / i_aes_cypher  in  1/1/128  AES core o_ready, o_valid pulse and o_cypher.
REQ-011 o_valid / o_data[RND_SIZE] / o_last  out  1/128/1  output block; held stable until i_ready.
REQ-012 i_ready  in  1  downstream accepts output when o_valid and i_ready are both high.
REQ-013 o_ek_j0 / o_ek_j0_valid  out  128/1  E(K,J0) for tag generation; valid is a one-cycle pulse.
REQ-014 o_busy  out  1  high whenever state is not IDLE.

Function
REQ-015 FSM states: IDLE, REQ_J0, WAIT_J0, WAIT_DATA, REQ_CTR, WAIT_CTR, OUT.
REQ-016 IDLE: on i_start, latch i_j0 into ctr_blk -> REQ_J0; i_start outside IDLE is ignored.
REQ-017 REQ_J0 / REQ_CTR: o_aes_en pulses for exactly one cycle, in the first cycle i_aes_ready is high, with o_aes_msg = ctr_blk; next state WAIT_J0 / WAIT_CTR.
REQ-018 At most one AES request is outstanding; o_aes_msg is held stable from the request until the matching i_aes_valid.
REQ-019 WAIT_J0: on i_aes_valid, o_ek_j0 <= i_aes_cypher, o_ek_j0_valid pulses the next cycle, ctr_blk <= inc32(ctr_blk) -> WAIT_DATA.
REQ-020 WAIT_DATA: o_data_ready = 1 (0 in every other state); on accept, latch i_data and i_data_last -> REQ_CTR.
REQ-021 WAIT_CTR: on i_aes_valid, o_data <= latched data XOR i_aes_cypher, o_last <= latched last, o_valid <= 1 -> OUT.
REQ-022 OUT: hold o_valid, o_data and o_last until i_ready; on handshake ctr_blk <= inc32(ctr_blk), o_valid <= 0, then IDLE if o_last else WAIT_DATA.
REQ-023 inc32: low CTR_SIZE bits increment modulo 2^CTR_SIZE; upper RND_SIZE-CTR_SIZE bits are never modified (0xFFFFFFFF wraps to 0x00000000).
REQ-024 i_aes_valid arriving in any state other than WAIT_J0 or WAIT_CTR is ignored.
REQ-025 Minimum latency from input accept to o_valid = 2 cycles plus the AES core latency; o_ek_j0_valid is asserted before o_data_ready is first asserted.
REQ-026 Encrypt and decrypt are identical (GCTR); there is no mode input.

Reset
REQ-027 rst in any state: state <= IDLE; ctr_blk, data latch, o_data, o_ek_j0 <= 0; o_valid, o_last, o_aes_en, o_ek_j0_valid, o_data_ready, o_busy <= 0.
REQ-028 rst during WAIT_J0 or WAIT_CTR abandons the outstanding request; a later i_aes_valid is ignored per REQ-024.

Structure
REQ-029 Shared package aes_pkg holds RND_SIZE, WRD_SIZE, CTR_SIZE and the FSM state enum type; the inc32 function also lives in aes_pkg.
REQ-030 No sub-module; aes_core_top is instantiated beside aes_gctr_ctrl at the next level up, not inside it.

Verification
REQ-031 Key 0, i_j0 = 0...01, one zero block with last=1 -> o_ek_j0 = 58e2fccefa7e3061367f1d57a4e7455a; o_data = 0388dace60b6a392f328c2b971b2fe78; o_last = 1; return to IDLE.
REQ-032 Echo AES stub (cypher = msg), i_j0 low word FFFFFFFE, 3 zero blocks -> o_data low words FFFFFFFF, 00000000, 00000001; upper 96 bits equal i_j0.
REQ-033 i_ready held low 5 cycles during OUT -> o_valid/o_data stable; o_data_ready = 0; no o_aes_en pulse.
REQ-034 i_aes_ready low 4 cycles in REQ_CTR -> o_aes_en pulses once, in the cycle i_aes_ready rises; o_aes_msg is unchanged.
REQ-035 rst asserted in WAIT_CTR, then stray i_aes_valid -> all outputs 0, state IDLE, no o_valid.
REQ-036 i_start pulsed in WAIT_DATA -> ignored; ctr_blk and o_busy are unchanged.
